fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of `decode`. It owns the PC register and a single-outstanding request/response handshake to instruction memory. It also contains a one-entry hold buffer and the IF/ID pipeline register that feeds `decode.instruction` and `decode.pc`. It obeys the hazard unit's `pc_enable`/`if_id_enable` stalls and the branch redirect/flush (`mux_sel_IF`, `pc_branch_value`, `IF_flush`) that `decode` produces.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP`, 32'h0000_0013, instruction word inserted as a bubble (addi x0,x0,0)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pc_enable`  in  1  from hazard unit; 0 = hold PC, issue no new request
- `if_id_enable`  in  1  from hazard unit; 0 = hold IF/ID contents
- `mux_sel_IF`  in  1  branch taken in decode; redirect PC to `pc_branch_value`
- `IF_flush`  in  1  squash the instruction fetched/held in IF
- `pc_branch_value`  in  32  branch target
- `imem_req`  out  1  request strobe; memory always accepts when high
- `imem_addr`  out  32  word-aligned fetch address, valid while `imem_req`=1
- `imem_ready`  in  1  response valid; one-cycle pulse, ≥1 cycle after the request
- `imem_rdata`  in  32  instruction word, valid while `imem_ready`=1
- `instruction_out`  out  32  IF/ID instruction
- `pc_out`  out  32  IF/ID PC of `instruction_out`
- `valid_out`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- One outstanding request maximum. FSM states are FETCH, WAIT, HOLD and DROP.
- `redirect` = `mux_sel_IF`. Target = `pc_branch_value`. In every state, a redirect never produces a fetch from the stale PC.
- **FETCH:**
  - `imem_req` = `pc_enable` & !`redirect`, and `imem_addr` = pc_reg.
  - If `redirect`: pc_reg ← target, stay in FETCH.
  - Else if `pc_enable`: go to WAIT.
  - Else stay in FETCH.
- **WAIT** (`imem_req`=0):
  - If `redirect` and no `imem_ready`: pc_reg ← target, go to DROP.
  - If `imem_ready` and (`redirect` | `IF_flush`): discard the data, pc_reg ← target if redirect (else unchanged), go to FETCH.
  - If `imem_ready` and `if_id_enable` & `pc_enable`: IF/ID ← {imem_rdata, pc_reg, valid=1}, pc_reg ← pc_reg+4, go to FETCH.
  - If `imem_ready` and stalled: hold buffer ← imem_rdata, go to HOLD.
- **HOLD:**
  - If `redirect` | `IF_flush`: drop the buffer, pc_reg ← target if redirect, go to FETCH.
  - Else if `if_id_enable` & `pc_enable`: IF/ID ← {buffer, pc_reg, 1}, pc_reg += 4, go to FETCH.
- **DROP:** wait for `imem_ready`, discard the data, then go to FETCH. pc_reg is already the target. A further redirect in DROP updates pc_reg again.
- **IF/ID register priority:** `IF_flush` > hold (`if_id_enable`=0) > load-new > load-bubble.
  - `IF_flush` forces {NOP, pc_out unchanged, valid=0} even when `if_id_enable`=0.
  - With `if_id_enable`=1 and no instruction delivered this cycle, IF/ID loads {NOP, pc_out unchanged, valid=0}.
- PC arithmetic is 32-bit modulo. 0xFFFF_FFFC + 4 wraps to 0. Bits [1:0] of the target are passed through unchanged; alignment is not checked.
- `imem_ready` in FETCH or HOLD is ignored. The memory shares `reset`.

## Timing
- **Reset (async, `reset`=0):**
  - pc_reg = RESET_PC, state = FETCH, instruction_out = NOP, pc_out = 0, valid_out = 0, buffer = 0.
  - `imem_req` is forced to 0 while reset is asserted.
  - The first request is issued in the first cycle after release.
- **Reset mid-operation:** any outstanding response is abandoned, and the state returns to FETCH immediately.
- **Latency:** memory latency L ≥ 1 gives an IF/ID update L cycles after the `imem_req` cycle. Peak throughput is one instruction per L+1 cycles.
- **Taken branch:** with `mux_sel_IF`=`IF_flush`=1 at edge N, the next request to the target is issued at cycle N+1 (FETCH/HOLD) or after the pending response (WAIT→DROP). The wrong-path instruction never sets `valid_out`.
- **Simultaneous `imem_ready` + `redirect`:** the data is discarded, and the next request is the target.

## Test plan
- **Reset and straight line (L=1, no stalls):** release reset → requests at 0, 4, 8. IF/ID shows pc_out 0, 4, 8 with the matching words, valid pulses every 2 cycles, and bubbles (NOP, valid=0) in between.
- **Stall during WAIT (L=3):** `if_id_enable`=`pc_enable`=0 is asserted when `imem_ready` pulses.
  - The word is held in HOLD, and IF/ID keeps its previous value.
  - After release, IF/ID = {word, pc} on the next edge, then pc+4 is requested.
- **Redirect in WAIT (L=3):** `mux_sel_IF`=1 with target 0x40 one cycle after the request to 0x8.
  - The 0x8 response is dropped (valid_out stays 0).
  - The next `imem_addr` is 0x40.
- **Redirect coincident with `imem_ready`:** the data is discarded, and the request to the target is issued on the next cycle.
- **Flush while stalled:** IF/ID holds a valid instruction with `if_id_enable`=0, then `IF_flush`=1 → IF/ID = NOP, valid_out=0 on the next edge.
- **Async reset asserted in DROP:** outputs return to their reset values immediately, and fetching restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, a single-outstanding imem handshake,
// a one-entry hold buffer for stalled responses, and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        if_id_enable,
    input  logic        mux_sel_IF,
    input  logic        IF_flush,
    input  logic [31:0] pc_branch_value,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] buf_r, buf_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] pc_out_r, pc_out_s;
    logic        valid_r, valid_s;
    logic        req_s;
    logic        deliver_s;
    logic [31:0] deliver_word_s;
    logic        squash_s;

    assign squash_s = mux_sel_IF | IF_flush;

    // Next-state, PC update and request strobe for the fetch handshake.
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        buf_s          = buf_r;
        req_s          = 1'b0;
        deliver_s      = 1'b0;
        deliver_word_s = buf_r;
        case (state_r)
            FETCH: begin
                req_s = pc_enable & ~mux_sel_IF;
                if (mux_sel_IF) begin
                    pc_s = pc_branch_value;
                end else if (pc_enable) begin
                    state_s = WAIT;
                end else begin
                    state_s = FETCH;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    if (squash_s) begin
                        state_s = FETCH;
                        if (mux_sel_IF) begin
                            pc_s = pc_branch_value;
                        end else begin
                            pc_s = pc_r;
                        end
                    end else if (if_id_enable & pc_enable) begin
                        deliver_s      = 1'b1;
                        deliver_word_s = imem_rdata;
                        state_s        = FETCH;
                    end else begin
                        buf_s   = imem_rdata;
                        state_s = HOLD;
                    end
                end else if (mux_sel_IF) begin
                    // Response still in flight: retarget now, swallow it later.
                    pc_s    = pc_branch_value;
                    state_s = DROP;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (squash_s) begin
                    state_s = FETCH;
                    if (mux_sel_IF) begin
                        pc_s = pc_branch_value;
                    end else begin
                        pc_s = pc_r;
                    end
                end else if (if_id_enable & pc_enable) begin
                    deliver_s      = 1'b1;
                    deliver_word_s = buf_r;
                    state_s        = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            DROP: begin
                if (mux_sel_IF) begin
                    pc_s = pc_branch_value;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_ready) begin
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = FETCH;
            end
        endcase
        if (deliver_s) begin
            pc_s = pc_r + 32'd4;
        end else begin
            pc_s = pc_s;
        end
    end

    // IF/ID next value: flush beats hold, hold beats a new load, otherwise a bubble.
    always_comb begin
        instr_s  = instr_r;
        pc_out_s = pc_out_r;
        valid_s  = valid_r;
        if (IF_flush) begin
            instr_s = NOP;
            valid_s = 1'b0;
        end else if (!if_id_enable) begin
            instr_s = instr_r;
            valid_s = valid_r;
        end else if (deliver_s) begin
            instr_s  = deliver_word_s;
            pc_out_s = pc_r;
            valid_s  = 1'b1;
        end else begin
            instr_s = NOP;
            valid_s = 1'b0;
        end
    end

    // State, PC, hold buffer and IF/ID registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= FETCH;
            pc_r     <= RESET_PC;
            buf_r    <= 32'h0000_0000;
            instr_r  <= NOP;
            pc_out_r <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            buf_r    <= buf_s;
            instr_r  <= instr_s;
            pc_out_r <= pc_out_s;
            valid_r  <= valid_s;
        end
    end

    // The request is combinational so a fetch leaves in the cycle the PC is ready.
    assign imem_req        = req_s & reset;
    assign imem_addr       = pc_r;
    assign instruction_out = instr_r;
    assign pc_out          = pc_out_r;
    assign valid_out       = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts requests
// and IF/ID contents per cycle; independent monitors pop and compare.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b1;
    logic        reset = 1'b0;
    logic        pc_enable = 1'b0;
    logic        if_id_enable = 1'b0;
    logic        mux_sel_IF = 1'b0;
    logic        IF_flush = 1'b0;
    logic [31:0] pc_branch_value = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;

    fetch_stage dut (
        .clock(clock), .reset(reset), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
        .mux_sel_IF(mux_sel_IF), .IF_flush(IF_flush), .pc_branch_value(pc_branch_value),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instruction_out(instruction_out), .pc_out(pc_out),
        .valid_out(valid_out)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic req; logic [31:0] addr; } req_exp_t;
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic valid; } ifid_exp_t;

    req_exp_t  req_q[$];
    ifid_exp_t ifid_q[$];
    int n_vec = 0;
    int n_fail = 0;
    bit active = 1'b0;

    // memory model state
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_fix;
    bit          stray_en;
    int          since_req;

    // reference model state
    logic [31:0] m_pc, m_buf, e_instr, e_pc;
    bit          m_out, m_drop, m_held, e_valid;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0; m_out = 0; m_drop = 0; m_held = 0;
        e_instr = NOP; e_pc = 32'h0; e_valid = 0;
    endtask

    // One clock of the fetch contract, expressed as "what is in flight / buffered".
    task automatic model_step(input bit live, input bit pce, input bit ide, input bit redir,
                              input bit flush, input logic [31:0] tgt, input bit rdy,
                              input logic [31:0] rdata, input bit kill);
        req_exp_t r;
        ifid_exp_t f;
        bit deliver;
        logic [31:0] d_word, d_pc;
        r.req  = live && !m_out && !m_held && pce && !redir;
        r.addr = m_pc;
        req_q.push_back(r);
        deliver = 0; d_word = 32'h0; d_pc = m_pc;
        if (!live || kill) begin
            model_reset();
        end else begin
            if (m_held) begin
                if (redir || flush) begin
                    m_held = 0;
                    if (redir) m_pc = tgt;
                end else if (ide && pce) begin
                    deliver = 1; d_word = m_buf; m_held = 0;
                end
            end else if (m_out) begin
                if (m_drop) begin
                    if (redir) m_pc = tgt;
                    if (rdy) begin m_out = 0; m_drop = 0; end
                end else if (rdy) begin
                    m_out = 0;
                    if (redir || flush) begin
                        if (redir) m_pc = tgt;
                    end else if (ide && pce) begin
                        deliver = 1; d_word = rdata;
                    end else begin
                        m_held = 1; m_buf = rdata;
                    end
                end else if (redir) begin
                    m_pc = tgt; m_drop = 1;
                end
            end else begin
                if (redir) m_pc = tgt;
                else if (pce) m_out = 1;
            end
            if (deliver) begin
                d_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
            if (flush) begin
                e_instr = NOP; e_valid = 0;
            end else if (ide) begin
                if (deliver) begin e_instr = d_word; e_pc = d_pc; e_valid = 1; end
                else begin e_instr = NOP; e_valid = 0; end
            end
        end
        f.instr = e_instr; f.pc = e_pc; f.valid = e_valid;
        ifid_q.push_back(f);
    endtask

    // Memory side of a cycle: decide imem_ready/imem_rdata for this cycle.
    task automatic mem_tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        if (reset && mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ready = 1'b1;
                imem_rdata = word_at(mem_addr);
                mem_pend = 0;
            end
        end else if (reset && stray_en && $urandom_range(15, 0) == 0) begin
            imem_ready = 1'b1;
        end
    endtask

    task automatic apply(input bit rst_v, input bit pce, input bit ide, input bit redir,
                         input bit flush, input logic [31:0] tgt, input bit kill);
        reset = rst_v; pc_enable = pce; if_id_enable = ide;
        mux_sel_IF = redir; IF_flush = flush; pc_branch_value = tgt;
        if (!rst_v) begin imem_ready = 1'b0; mem_pend = 0; end
        #1;
        if (rst_v && imem_req === 1'b1) begin
            mem_pend = 1; mem_addr = imem_addr; since_req = 0;
            mem_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(4, 1));
        end else begin
            since_req++;
        end
        model_step(rst_v, pce, ide, redir, flush, tgt, imem_ready, imem_rdata, kill);
        active = 1'b1;
        if (kill) begin
            #2;
            reset = 1'b0; imem_ready = 1'b0; mem_pend = 0;
            #1;
            chk("async_rst_req", {31'h0, imem_req}, 32'h0);
            chk("async_rst_instr", instruction_out, NOP);
            chk("async_rst_pc", pc_out, 32'h0);
            chk("async_rst_valid", {31'h0, valid_out}, 32'h0);
        end
    endtask

    // Request monitor.
    initial forever begin
        @(negedge clock); #2;
        if (active) begin
            if (req_q.size() == 0) begin
                chk("req_queue_underflow", 32'h1, 32'h0);
            end else begin
                req_exp_t r;
                r = req_q.pop_front();
                chk("imem_req", {31'h0, imem_req}, {31'h0, r.req});
                if (r.req) chk("imem_addr", imem_addr, r.addr);
            end
        end
    end

    // IF/ID monitor.
    initial forever begin
        @(posedge clock); #1;
        if (active) begin
            if (ifid_q.size() == 0) begin
                chk("ifid_queue_underflow", 32'h1, 32'h0);
            end else begin
                ifid_exp_t f;
                f = ifid_q.pop_front();
                chk("instruction_out", instruction_out, f.instr);
                chk("pc_out", pc_out, f.pc);
                chk("valid_out", {31'h0, valid_out}, {31'h0, f.valid});
            end
        end
    end

    initial begin
        int st, fs, cnt;
        bit done;
        logic [31:0] tgt;
        bit pce, ide, redir, flush;
        model_reset();
        since_req = 100; lat_fix = 1; stray_en = 0; mem_pend = 0; mem_cnt = 0; mem_addr = 32'h0;

        repeat (3) begin @(negedge clock); mem_tick(); apply(0, 1, 1, 0, 0, 32'h0, 0); end

        // straight line, latency 1
        lat_fix = 1;
        repeat (10) begin @(negedge clock); mem_tick(); apply(1, 1, 1, 0, 0, 32'h0, 0); end

        // stall while the response arrives, latency 3
        lat_fix = 3; st = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock); mem_tick();
            if (imem_ready) st = 3;
            if (st > 0) begin st--; apply(1, 0, 0, 0, 0, 32'h0, 0); end
            else apply(1, 1, 1, 0, 0, 32'h0, 0);
        end

        // redirect one cycle after a request
        done = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock); mem_tick();
            if (!done && since_req == 0) begin done = 1; apply(1, 1, 1, 1, 1, 32'h40, 0); end
            else apply(1, 1, 1, 0, 0, 32'h0, 0);
        end

        // redirect coincident with the response
        lat_fix = 2; done = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock); mem_tick();
            if (!done && imem_ready) begin done = 1; apply(1, 1, 1, 1, 1, 32'h100, 0); end
            else apply(1, 1, 1, 0, 0, 32'h0, 0);
        end

        // PC wrap past the top of the address space
        lat_fix = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); mem_tick();
            apply(1, 1, 1, i == 0, i == 0, 32'hFFFF_FFF8, 0);
        end

        // flush while IF/ID is held with a valid instruction
        fs = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); mem_tick();
            case (fs)
                0: if (e_valid) begin fs = 1; cnt = 0; apply(1, 0, 0, 0, 0, 32'h0, 0); end
                   else apply(1, 1, 1, 0, 0, 32'h0, 0);
                1: begin cnt++; if (cnt == 2) fs = 2; apply(1, 0, 0, 0, 0, 32'h0, 0); end
                2: begin fs = 3; apply(1, 0, 0, 0, 1, 32'h0, 0); end
                default: apply(1, 1, 1, 0, 0, 32'h0, 0);
            endcase
        end

        // randomized traffic
        lat_fix = 0; stray_en = 1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock); mem_tick();
            pce = ($urandom_range(3, 0) != 0);
            ide = ($urandom_range(3, 0) != 0);
            redir = ($urandom_range(7, 0) == 0);
            flush = redir ? ($urandom_range(3, 0) != 0) : ($urandom_range(15, 0) == 0);
            case ($urandom_range(7, 0))
                0: tgt = 32'hFFFF_FFFC;
                1: tgt = $urandom;
                default: tgt = 32'($urandom_range(1023, 0)) << 2;
            endcase
            apply(1, pce, ide, redir, flush, tgt, 0);
        end

        // async reset while a redirected response is being dropped
        stray_en = 0; lat_fix = 3; fs = 0;
        for (int i = 0; i < 30 && fs < 2; i++) begin
            @(negedge clock); mem_tick();
            if (fs == 0 && since_req == 0 && !imem_ready) begin fs = 1; apply(1, 1, 1, 1, 1, 32'h80, 0); end
            else if (fs == 1) begin fs = 2; apply(1, 1, 1, 0, 0, 32'h0, 1); end
            else apply(1, 1, 1, 0, 0, 32'h0, 0);
        end
        chk("drop_reset_reached", {30'h0, fs[1:0]}, 32'd2);
        repeat (2) begin @(negedge clock); mem_tick(); apply(0, 1, 1, 0, 0, 32'h0, 0); end
        lat_fix = 1;
        repeat (8) begin @(negedge clock); mem_tick(); apply(1, 1, 1, 0, 0, 32'h0, 0); end

        @(posedge clock); #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
